uart_rx: RTL and testbench

Asynchronous serial receiver that turns the board's UART RX pin into a byte stream of `uart_rx_data_out` plus a one-cycle `uart_rx_data_valid` strobe. It sits directly upstream of the UART payload extractor, which decodes command opcodes such as 0xFE00 (dump book) from that stream. The frame format is fixed at 8N1, LSB first, with a mid-bit sampling point and framing-error detection.

---
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first asynchronous serial receiver.
// The RX pin is double-flopped into rxs. Each bit is sampled at its midpoint,
// timed from the detected falling edge of the start bit. A good frame produces
// a one-cycle data_valid pulse. A low stop bit produces a one-cycle frame_err
// pulse, and the receiver then parks in BREAK until the line returns high.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_serial,
  output logic [7:0] uart_rx_data_out,
  output logic       uart_rx_data_valid,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_busy
);

  // Fewer than 4 clocks per bit leaves no usable mid-bit sampling margin.
  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_rx: CLKS_PER_BIT must be >= 4");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);

  // START waits to the middle of the start bit. Every later bit is one full bit period on.
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic          sync1_q;
  logic          sync2_q;
  logic          rxs;
  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [CW-1:0] clk_cnt_q;
  logic [CW-1:0] clk_cnt_d;
  logic [2:0]    bit_idx_q;
  logic [2:0]    bit_idx_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic [7:0]    data_q;
  logic [7:0]    data_d;
  logic          valid_q;
  logic          valid_d;
  logic          ferr_q;
  logic          ferr_d;
  logic          busy_q;
  logic          busy_d;

  // Two-flop synchronizer. Both flops reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx_serial;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // Next-state logic: frame sequencing, bit capture and output pulses.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = {CW{1'b0}};
        bit_idx_d = 3'd0;
        if (rxs == 1'b0) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (clk_cnt_q == HALF_CNT) begin
          clk_cnt_d = {CW{1'b0}};
          if (rxs == 1'b0) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            // The line went high again before mid-bit, so this was a glitch, not a start bit.
            state_d = ST_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      ST_DATA: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d          = {CW{1'b0}};
          shift_d[bit_idx_q] = rxs;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      ST_STOP: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d = {CW{1'b0}};
          if (rxs == 1'b1) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // data_out keeps the last good byte. BREAK absorbs a held-low line.
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      ST_BREAK: begin
        clk_cnt_d = {CW{1'b0}};
        if (rxs == 1'b1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end

      default: begin
        clk_cnt_d = {CW{1'b0}};
        bit_idx_d = 3'd0;
        state_d   = ST_IDLE;
      end
    endcase

    // busy is registered from the next state, so it tracks state_q with no extra delay.
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= {CW{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign uart_rx_data_out   = data_q;
  assign uart_rx_data_valid = valid_q;
  assign uart_rx_frame_err  = ferr_q;
  assign uart_rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. Directed scenarios are followed by randomized, baud-skewed frames.
// Each directed scenario is checked against values the bench computes itself.
// Every cycle, the pin and reset levels are recorded. A reference decoder then
// derives the expected pulse list from those recordings, using the sample-instant
// arithmetic of the frame format.
module tb_uart_rx;

  localparam int CPB      = 16;
  localparam int H        = (CPB - 1) / 2;
  localparam int LAT      = 4 + H + 9 * CPB;      // pin fall cycle -> pulse cycle
  localparam int CPB_DEF  = 868;
  localparam int LAT_DEF  = 4 + (CPB_DEF - 1) / 2 + 9 * CPB_DEF;
  localparam int MAXC     = 32768;

  typedef struct {
    int         c;
    bit         fe;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_pin;
  logic       pin_def;
  logic [7:0] dout;
  logic       vld;
  logic       fe;
  logic       busy;
  logic [7:0] def_dout;
  logic       def_vld;
  logic       def_fe;
  logic       def_busy;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  logic pin_hist [MAXC];
  logic rst_hist [MAXC];
  ev_t obs[$];
  ev_t expq[$];
  int  def_cnt = 0;
  int  def_fe_cnt = 0;
  int  def_cyc = -1;
  logic [7:0] def_data = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_serial(uart_pin),
    .uart_rx_data_out(dout), .uart_rx_data_valid(vld),
    .uart_rx_frame_err(fe), .uart_rx_busy(busy)
  );

  uart_rx u_dut_def (
    .clk(clk), .rst_n(rst_n), .uart_rx_serial(pin_def),
    .uart_rx_data_out(def_dout), .uart_rx_data_valid(def_vld),
    .uart_rx_frame_err(def_fe), .uart_rx_busy(def_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the line and reset levels of each cycle, and log every output pulse.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      pin_hist[cyc] <= uart_pin;
      rst_hist[cyc] <= !rst_n;
    end
    if (vld || fe) begin
      ev_t e;
      checks++;
      assert (!(vld && fe)) else begin
        errors++;
        $error("FAIL excl: valid=%0b frame_err=%0b both high at cycle %0d", vld, fe, cyc);
      end
      e.c = cyc; e.fe = fe; e.d = dout;
      obs.push_back(e);
    end
    if (def_vld) begin
      def_cnt <= def_cnt + 1;
      def_cyc <= cyc;
      def_data <= def_dout;
    end
    if (def_fe) def_fe_cnt <= def_fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input int idx, input int ecyc, input bit efe, input logic [7:0] ed);
    chk({tag, "_present"}, 32'(idx < obs.size()), 32'd1);
    if (idx < obs.size()) begin
      chk({tag, "_cycle"}, obs[idx].c, ecyc);
      chk({tag, "_kind"}, 32'(obs[idx].fe), 32'(efe));
      chk({tag, "_data"}, 32'(obs[idx].d), 32'(ed));
    end
  endtask

  // Drive one 10-bit frame; bit n occupies TX time [n*per, (n+1)*per), per = per100/100 cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per100,
                            input bit on_def, output int t_fall);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    t_fall = cyc;
    for (int e = 0; e * 100 < 10 * per100; e++) begin
      if (on_def) pin_def = bits[(e * 100) / per100];
      else        uart_pin = bits[(e * 100) / per100];
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    uart_pin = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // rxs as defined by the two-stage synchronizer, forced high around reset.
  function automatic logic rxs_at(input int c);
    if (c < 2) return 1'b1;
    if (rst_hist[c] || rst_hist[c-1] || rst_hist[c-2]) return 1'b1;
    return pin_hist[c-2];
  endfunction

  function automatic int first_rst(input int a, input int b);
    for (int i = a; i <= b; i++) if (rst_hist[i]) return i;
    return -1;
  endfunction

  // Reference decoder: walk the recorded rxs, sample at the mid-bit instants, list expected pulses.
  task automatic run_model(input int end_c);
    int t, ss, s, r;
    logic [7:0] last, d;
    ev_t e;
    t = 0; last = 8'h00;
    while (t < end_c) begin
      if (rst_hist[t]) begin
        last = 8'h00; t++;
      end else if (rxs_at(t)) begin
        t++;
      end else begin
        ss = t + 1 + H;
        s  = t + 1 + H + 9 * CPB;
        if (s + 1 >= end_c) t = end_c;
        else begin
          r = first_rst(t + 1, ss);
          if (r >= 0) t = r;
          else if (rxs_at(ss)) t = ss + 1;
          else begin
            r = first_rst(t + 1, s + 1);
            if (r >= 0) t = r;
            else begin
              for (int k = 0; k < 8; k++) d[k] = rxs_at(ss + (k + 1) * CPB);
              e.c = s + 1;
              if (rxs_at(s)) begin
                e.fe = 1'b0; e.d = d; last = d;
                expq.push_back(e);
                t = s + 1;
              end else begin
                e.fe = 1'b1; e.d = last;
                expq.push_back(e);
                t = s + 1;
                while (t < end_c && !rst_hist[t] && !rxs_at(t)) t++;
                if (t < end_c && !rst_hist[t]) t++;
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    int c1, c2, c, cf, c55, cd, mark, nbusy, first, bad, gap, fc[6];
    logic [7:0] sk_bytes[3];
    int pers[2];
    logic [7:0] rb;
    sk_bytes = '{8'h00, 8'hFF, 8'h5A};
    pers = '{1648, 1552};

    uart_pin = 1'b1; pin_def = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", 32'(dout), 32'h00);
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_ferr", 32'(fe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(10);

    // Back-to-back 0xFE, 0x00 with zero idle gap.
    mark = obs.size();
    send_frame(8'hFE, 1'b1, 1600, 1'b0, c1);
    send_frame(8'h00, 1'b1, 1600, 1'b0, c2);
    idle(30);
    chk("b2b_count", obs.size() - mark, 32'd2);
    chk_ev("b2b_fe", mark, c1 + LAT, 1'b0, 8'hFE);
    chk_ev("b2b_00", mark + 1, c2 + LAT, 1'b0, 8'h00);

    // Three-cycle glitch: busy for H+1 cycles, no pulse, data held.
    mark = obs.size();
    c = cyc; uart_pin = 1'b0; nbusy = 0; first = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) begin
        nbusy++;
        if (first < 0) first = cyc;
      end
      @(posedge clk); #1;
      if (cyc == c + 3) uart_pin = 1'b1;
    end
    chk("glitch_busy_len", nbusy, H + 1);
    chk("glitch_busy_start", first, c + 3);
    chk("glitch_pulses", obs.size() - mark, 32'd0);
    chk("glitch_data", 32'(dout), 32'h00);

    // Framing error followed by a 40-bit break, then a good byte.
    send_frame(8'hC3, 1'b1, 1600, 1'b0, c);
    idle(20);
    chk("pre_ferr_data", 32'(dout), 32'hC3);
    mark = obs.size();
    send_frame(8'hA5, 1'b0, 1600, 1'b0, cf);
    uart_pin = 1'b0;
    repeat (320) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("break_busy", 32'(busy), 32'd1);
    repeat (320) begin @(posedge clk); #1; end
    chk("break_pulses", obs.size() - mark, 32'd1);
    chk_ev("ferr", mark, cf + LAT, 1'b1, 8'hC3);
    chk("ferr_data_hold", 32'(dout), 32'hC3);
    idle(32);
    mark = obs.size();
    send_frame(8'h3C, 1'b1, 1600, 1'b0, c);
    idle(30);
    chk("after_break_count", obs.size() - mark, 32'd1);
    chk_ev("after_break", mark, c + LAT, 1'b0, 8'h3C);

    // Reset asserted for 5 cycles during data bit 4 of 0x55.
    mark = obs.size();
    fork
      send_frame(8'h55, 1'b1, 1600, 1'b0, c55);
      begin
        repeat (85) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_data", 32'(dout), 32'h00);
        chk("midrst_valid", 32'(vld), 32'd0);
        chk("midrst_ferr", 32'(fe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    idle(200);
    bad = 0;
    for (int i = mark; i < obs.size(); i++) if (obs[i].d === 8'h55) bad++;
    chk("midrst_no_55", bad, 32'd0);
    mark = obs.size();
    send_frame(8'h81, 1'b1, 1600, 1'b0, c);
    idle(30);
    chk_ev("post_rst_81", mark, c + LAT, 1'b0, 8'h81);

    // Baud skew +3% then -3%, all frames back-to-back.
    mark = obs.size();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k++)
        send_frame(sk_bytes[k], 1'b1, pers[p], 1'b0, fc[p * 3 + k]);
    idle(40);
    chk("skew_count", obs.size() - mark, 32'd6);
    for (int i = 0; i < 6; i++)
      chk_ev($sformatf("skew%0d", i), mark + i, fc[i] + LAT, 1'b0, sk_bytes[i % 3]);

    // Random bytes, random skew, occasional bad stop bit, random gaps.
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, ($urandom_range(0, 7) != 0), int'($urandom_range(1552, 1648)), 1'b0, c);
      gap = int'($urandom_range(0, 20));
      idle(gap);
    end
    idle(300);

    // Compare every observed pulse against the reference decoder.
    run_model(cyc);
    chk("model_count", obs.size(), expq.size());
    for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
      chk($sformatf("model%0d_cycle", i), obs[i].c, expq[i].c);
      chk($sformatf("model%0d_kind", i), 32'(obs[i].fe), 32'(expq[i].fe));
      chk($sformatf("model%0d_data", i), 32'(obs[i].d), 32'(expq[i].d));
    end

    // Default CLKS_PER_BIT instance: 0x7E with exact pulse cycle.
    send_frame(8'h7E, 1'b1, CPB_DEF * 100, 1'b1, cd);
    idle(50);
    chk("def_count", def_cnt, 32'd1);
    chk("def_cycle", def_cyc, cd + LAT_DEF);
    chk("def_data", 32'(def_data), 32'h7E);
    chk("def_ferr", def_fe_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
